// File: rtl/fb_pkg.sv
// Shared framebuffer types: colour widths, the frame walker state encoding
// (also used by the rasterizer) and the pixel-plus-flags entry.
package fb_pkg;

    localparam int COLOR_W = 4;
    localparam int PIXEL_W = 3 * COLOR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [PIXEL_W-1:0] rgb;
        logic               line_last;
        logic               frame_last;
    } fb_pixel_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO holding returned pixels between the framebuffer read port
// and the downstream stream; the caller guarantees it is never pushed when full.
module pixel_skid_fifo
    import fb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       i_push,
    input  fb_pixel_t  i_data,
    input  logic       i_pop,
    output fb_pixel_t  o_head,
    output logic [1:0] o_count
);

    fb_pixel_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_pop;

    assign do_pop = i_pop && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        if (i_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!i_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (i_push) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/framebuffer_reader.sv
// Walks the framebuffer in raster order with one-cycle-latency reads and
// streams the pixels out on valid/ready, using read credits against a 2-entry buffer.
module framebuffer_reader
    import fb_pkg::*;
#(
    parameter int VERT_RESOLUTION  = 60,
    parameter int HORIZ_RESOLUTION = 80
) (
    input  logic                                i_clk,
    input  logic                                i_arst_n,
    input  logic                                i_go,
    output logic [$clog2(VERT_RESOLUTION)-1:0]  o_vert_read_addr,
    output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_horiz_read_addr,
    output logic                                o_read_en,
    input  logic [COLOR_W-1:0]                  i_red,
    input  logic [COLOR_W-1:0]                  i_green,
    input  logic [COLOR_W-1:0]                  i_blue,
    output logic [COLOR_W-1:0]                  o_red,
    output logic [COLOR_W-1:0]                  o_green,
    output logic [COLOR_W-1:0]                  o_blue,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic                                o_line_last,
    output logic                                o_frame_last,
    output logic                                o_busy,
    output logic                                o_done,
    output fb_state_t                           o_state
);

    localparam int VW = $clog2(VERT_RESOLUTION);
    localparam int HW = $clog2(HORIZ_RESOLUTION);
    localparam logic [VW-1:0] ROW_LAST = VW'(VERT_RESOLUTION - 1);
    localparam logic [HW-1:0] COL_LAST = HW'(HORIZ_RESOLUTION - 1);

    // Stream handshake: a pixel moves downstream on every rising edge where
    // o_valid && i_ready; o_valid never depends on i_ready and the head holds while stalled.

    fb_state_t     state_q;
    logic [VW-1:0] row_q;
    logic [HW-1:0] col_q;
    logic          inflight_q;
    logic          infl_line_q;
    logic          infl_frame_q;
    logic          done_q;

    fb_pixel_t     fifo_in;
    fb_pixel_t     fifo_head;
    logic [1:0]    fifo_count;
    logic          valid;
    logic          pop;
    logic          col_last;
    logic          row_last;
    logic [2:0]    credit_used;
    logic          read_en;

    assign valid    = (fifo_count != 2'd0);
    assign pop      = valid && i_ready;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    // A slot freed by this cycle's pop can be reused by this cycle's read.
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign read_en     = (state_q == READ) && (credit_used < 3'd2);

    assign fifo_in = {i_red, i_green, i_blue, infl_line_q, infl_frame_q};

    pixel_skid_fifo u_fifo (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_push   (inflight_q),
        .i_data   (fifo_in),
        .i_pop    (pop),
        .o_head   (fifo_head),
        .o_count  (fifo_count)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            inflight_q   <= 1'b0;
            infl_line_q  <= 1'b0;
            infl_frame_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            inflight_q <= read_en;
            done_q     <= 1'b0;
            if (read_en) begin
                infl_line_q  <= col_last;
                infl_frame_q <= col_last && row_last;
            end
            case (state_q)
                IDLE: begin
                    // A start request coinciding with the done pulse is not a new frame.
                    if (i_go && !done_q) begin
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (read_en) begin
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                row_q   <= '0;
                                state_q <= DRAIN;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_head.frame_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_vert_read_addr  = row_q;
    assign o_horiz_read_addr = col_q;
    assign o_read_en         = read_en;
    assign o_valid           = valid;
    assign o_red             = valid ? fifo_head.rgb[PIXEL_W-1 -: COLOR_W]           : '0;
    assign o_green           = valid ? fifo_head.rgb[PIXEL_W-COLOR_W-1 -: COLOR_W]   : '0;
    assign o_blue            = valid ? fifo_head.rgb[COLOR_W-1:0]                    : '0;
    assign o_line_last       = valid && fifo_head.line_last;
    assign o_frame_last      = valid && fifo_head.frame_last;
    assign o_busy            = (state_q != IDLE);
    assign o_done            = done_q;
    assign o_state           = state_q;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Bench for framebuffer_reader: memory model, expected-pixel queue per frame,
// negedge monitor comparing every transfer and every read address.
module tb_framebuffer_reader;
    import fb_pkg::*;

    localparam int V = 60;
    localparam int H = 80;
    localparam int N = V * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       go = 1'b0;
    logic       ready = 1'b0;
    logic [5:0] vaddr;
    logic [6:0] haddr;
    logic       rd_en;
    logic [3:0] ired = '0, igreen = '0, iblue = '0;
    logic [3:0] ored, ogreen, oblue;
    logic       valid, line_last, frame_last, busy, done;
    fb_state_t  st;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [13:0] exp_q[$];
    int         rd_idx = 0;
    int         reads = 0;
    int         xfers = 0;
    logic       rand_ready = 1'b0;
    logic       stall_prev = 1'b0;
    logic [13:0] prev_head = '0;
    logic       pend = 1'b0;
    logic [5:0] pend_v = '0;
    logic [6:0] pend_h = '0;

    framebuffer_reader #(.VERT_RESOLUTION(V), .HORIZ_RESOLUTION(H)) dut (
        .i_clk             (clk),
        .i_arst_n          (rst_n),
        .i_go              (go),
        .o_vert_read_addr  (vaddr),
        .o_horiz_read_addr (haddr),
        .o_read_en         (rd_en),
        .i_red             (ired),
        .i_green           (igreen),
        .i_blue            (iblue),
        .o_red             (ored),
        .o_green           (ogreen),
        .o_blue            (oblue),
        .o_valid           (valid),
        .i_ready           (ready),
        .o_line_last       (line_last),
        .o_frame_last      (frame_last),
        .o_busy            (busy),
        .o_done            (done),
        .o_state           (st)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model: data the cycle after the read ----------------
    always @(posedge clk) begin
        #1;
        if (pend) {ired, igreen, iblue} = {pend_v[3:0], pend_h[3:0], 4'h0};
        else      {ired, igreen, iblue} = 12'($urandom);
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [13:0] head;
        logic [13:0] e;
        head = {ored, ogreen, oblue, line_last, frame_last};
        if (rst_n) begin
            check("occupancy_le_2", 64'((reads - xfers) <= 2), 64'd1);
            if (stall_prev) check("head_stable", 64'(head), 64'(prev_head));
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 64'(head), 64'h3fff_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 64'(head), 64'(e));
                end
                xfers++;
            end
            stall_prev = valid && !ready;
            prev_head  = head;
            if (rd_en) begin
                check("read_row", 64'(vaddr), 64'(rd_idx / H));
                check("read_col", 64'(haddr), 64'(rd_idx % H));
                rd_idx = (rd_idx + 1) % N;
                reads++;
                pend   = 1'b1;
                pend_v = vaddr;
                pend_h = haddr;
            end else begin
                pend = 1'b0;
            end
        end else begin
            pend = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic flush_model();
        exp_q.delete();
        rd_idx     = 0;
        reads      = 0;
        xfers      = 0;
        stall_prev = 1'b0;
    endtask

    // Leaves time at edge0 + 2, so the next negedge is cycle 1.
    task automatic start_frame();
        @(posedge clk);
        #2;
        go = 1'b1;
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                exp_q.push_back({4'(r), 4'(c), 4'h0, 1'(c == H - 1), 1'((r == V - 1) && (c == H - 1))});
        @(posedge clk);
        #2;
        go = 1'b0;
    endtask

    task automatic wait_done(input int start_cyc, input int budget, output int cyc);
        cyc = start_cyc;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < budget);
        check("done_seen", 64'(done), 64'd1);
        check("busy_low_at_done", 64'(busy), 64'd0);
        check("all_pixels_out", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic idle_check(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check(name, 64'({rd_en, busy, valid, st}), 64'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int k;
        int r0;

        // Reset mid-cycle: outputs must clear immediately.
        #3 rst_n = 1'b0;
        #1;
        check("reset_outputs", 64'({vaddr, haddr, rd_en, ored, ogreen, oblue, valid,
                                    line_last, frame_last, busy, done, st}), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle_check(20, "idle_no_read");

        // Full frame at full rate with exact latencies.
        ready = 1'b1;
        start_frame();
        @(negedge clk);
        check("read_en_cycle1", 64'({rd_en, vaddr, haddr}), 64'({1'b1, 6'd0, 7'd0}));
        check("valid_cycle1", 64'(valid), 64'd0);
        @(negedge clk);
        check("valid_cycle2", 64'(valid), 64'd0);
        @(negedge clk);
        check("valid_cycle3", 64'(valid), 64'd1);
        wait_done(3, 6000, cyc);
        check("done_cycle", 64'(cyc), 64'(N + 3));

        // Random 50% backpressure.
        rand_ready = 1'b1;
        start_frame();
        wait_done(0, 30000, cyc);
        rand_ready = 1'b0;

        // Ready held low: exactly two reads, then resume at (0,2).
        @(posedge clk);
        #2 ready = 1'b0;
        r0 = reads;
        start_frame();
        repeat (20) @(negedge clk);
        check("stall_reads", 64'(reads - r0), 64'd2);
        check("stall_next_index", 64'(rd_idx), 64'd2);
        @(posedge clk);
        #2 ready = 1'b1;
        wait_done(0, 6000, cyc);

        // go during READ and around completion must not restart.
        start_frame();
        repeat (100) @(posedge clk);
        #2 go = 1'b1;
        @(posedge clk);
        #2 go = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(valid && frame_last) && k < 6000);
        check("frame_last_seen", 64'(valid && frame_last), 64'd1);
        go = 1'b1;
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        @(posedge clk);
        #2 go = 1'b0;
        check("no_restart_queue", 64'(exp_q.size()), 64'd0);
        idle_check(10, "no_restart");
        start_frame();
        wait_done(0, 6000, cyc);

        // Asynchronous reset mid-frame with a read in flight.
        rand_ready = 1'b1;
        start_frame();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(xfers >= 1000 && rd_en) && k < 20000);
        check("reached_pixel_1000", 64'(xfers >= 1000), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        flush_model();
        #1;
        check("midframe_reset", 64'({valid, busy, rd_en, done, st}), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        rand_ready = 1'b0;
        ready = 1'b1;
        idle_check(5, "post_reset_idle");
        start_frame();
        wait_done(0, 6000, cyc);
        check("restart_done_cycle", 64'(cyc), 64'(N + 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/framebuffer_reader.md
# framebuffer_reader

Read-side partner of the rasterizer: once a frame has been rasterized into the framebuffer, this block walks the same VERT_RESOLUTION x HORIZ_RESOLUTION address space in raster order. It issues one-cycle-latency reads and delivers the 12-bit RGB pixels downstream (display/scanout) on a valid/ready stream. A 2-entry buffer with credit-based read issue absorbs backpressure without losing the in-flight read. It signals completion when the last pixel of the frame is accepted.

## Interface
Parameters:
- VERT_RESOLUTION, 60, number of rows
- HORIZ_RESOLUTION, 80, number of columns

Ports:
- i_clk  input  1  single clock, all logic rising-edge
- i_arst_n  input  1  reset, asynchronous and active-low
- i_go  input  1  start one frame read; sampled only in IDLE
- o_vert_read_addr  output  $clog2(VERT_RESOLUTION)  framebuffer row address
- o_horiz_read_addr  output  $clog2(HORIZ_RESOLUTION)  framebuffer column address
- o_read_en  output  1  read strobe; memory returns data exactly 1 cycle later
- i_red, i_green, i_blue  input  4 each  framebuffer read data, valid the cycle after o_read_en
- o_red, o_green, o_blue  output  4 each  pixel at buffer head
- o_valid  output  1  pixel at head is valid
- i_ready  input  1  downstream accepts; transfer when o_valid && i_ready
- o_line_last  output  1  head pixel is column HORIZ_RESOLUTION-1
- o_frame_last  output  1  head pixel is (VERT_RESOLUTION-1, HORIZ_RESOLUTION-1)
- o_busy  output  1  high from leaving IDLE until final transfer
- o_done  output  1  one-cycle pulse after final transfer

## Operation
- Reset values: all outputs 0, state IDLE, buffer empty, in-flight flag 0.
- States: IDLE -> READ on i_go. READ -> DRAIN after the read of the last address issues. DRAIN -> IDLE on the o_frame_last transfer; o_done is pulsed that same edge.
- i_go is ignored outside IDLE. i_go in the same cycle as the DRAIN->IDLE transition is also ignored.
- Address walk: column increments. At HORIZ_RESOLUTION-1 the column wraps to 0 and the row increments. The read at (V-1,H-1) is the last one, after which both addresses return to 0.
- Addresses are held stable while o_read_en is 0.
- Credit rule: o_read_en = (state==READ) && (count + inflight - pop) < 2.
  - count is the buffer occupancy, 0..2.
  - inflight is 1 if a read was issued the previous cycle.
  - pop is o_valid && i_ready.
- Buffer overflow is therefore impossible. Returned data is always written, and the memory is never re-read.
- Buffer entry = {rgb[11:0], line_last, frame_last}. The flags are computed from the address at issue time and carried with the read.
- Simultaneous push and pop keeps count unchanged, and ordering is FIFO.
- Head output holds stable while o_valid && !i_ready.
- Asynchronous reset mid-frame returns the block to IDLE with the buffer flushed. Any read returning after reset is discarded.

## Timing
- i_go high at edge 0 gives o_read_en=1 for (0,0) in cycle 1, data on i_* in cycle 2, and o_valid=1 in cycle 3.
- With i_ready held high: one read per cycle and one transfer per cycle, no bubbles. The whole frame takes V*H+3 cycles from i_go to o_done.
- i_ready low for N cycles: reads stop once count+inflight reaches 2. Streaming resumes at the full rate on the cycle after i_ready returns high.
- o_busy falls and o_done rises on the same edge; o_done lasts 1 cycle.

## Structure
- Shared package fb_pkg:
  - COLOR_W=4 and PIXEL_W=12.
  - The state typedef {IDLE, READ, DRAIN}, which the rasterizer adopts as well.
  - The pixel-plus-flags struct.
- Sub-module pixel_skid_fifo: a 2-entry synchronous FIFO with push, pop, count, and head data, and asynchronous active-low reset. The top level holds the FSM, the address counters, and the credit logic.

## Test plan
- Reset/idle: assert i_arst_n=0 mid-cycle -> all outputs 0 immediately; i_go low for 20 cycles -> o_read_en never rises.
- Full frame, i_ready=1, memory returns rgb={row[3:0],col[3:0],4'h0} -> exactly 4800 transfers in raster order. o_line_last is seen on every 80th transfer and o_frame_last only on the last; o_done arrives at cycle 4803.
- Random backpressure (i_ready 50%) -> same 4800-pixel sequence, no drops or duplicates, count never exceeds 2. Heads are stable while stalled.
- i_ready held 0 from cycle 0 -> exactly 2 reads are issued, then o_read_en stays 0. Raising i_ready resumes the stream with (0,2) read next.
- i_go pulsed during READ and again on the o_done cycle -> no restart; only a later i_go in IDLE starts a second identical frame.
- Reset asserted at pixel 1000 with a read in flight -> IDLE, o_valid=0. The next i_go restarts from (0,0) with no stale pixel emitted.
